// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: merges NUM_REQS execution-unit commit streams into one
// ack-free writeback stream. Round-robin between packets, grant locked to a
// source for the duration of a multi-beat packet, one registered output beat.
module vx_writeback_arb #(
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_W       = 2,
    parameter int UUID_W      = 44,
    localparam int IN_W  = UUID_W + WIS_W + NUM_THREADS + NR_BITS + 1 + NUM_THREADS * XLEN + 2,
    localparam int OUT_W = UUID_W + WIS_W + NUM_THREADS + NR_BITS + NUM_THREADS * XLEN + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           commit_valid,
    output logic [NUM_REQS-1:0]           commit_ready,
    input  logic [NUM_REQS-1:0][IN_W-1:0] commit_data,
    output logic                          writeback_valid,
    output logic [OUT_W-1:0]              writeback_data,
    output logic [31:0]                   perf_stalls
);

    localparam int DATA_W = NUM_THREADS * XLEN;
    localparam int IDX_W  = $clog2(NUM_REQS);

    typedef struct packed {
        logic [UUID_W-1:0]      uuid;
        logic [WIS_W-1:0]       wis;
        logic [NUM_THREADS-1:0] tmask;
        logic [NR_BITS-1:0]     rd;
        logic                   wb;
        logic [DATA_W-1:0]      data;
        logic                   sop;
        logic                   eop;
    } commit_t;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_lock_src;
    logic [IDX_W-1:0]    w_lock_src_next;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    w_rr_ptr_next;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_gnt_any;
    logic [NUM_REQS-1:0] w_ready;
    commit_t             w_beat;
    logic                w_emit;
    logic                w_stall;
    logic                r_wb_valid;
    logic [OUT_W-1:0]    r_wb_data;
    logic [31:0]         r_perf;

    // Grant selection: the lock owner while locked (bubble if it is idle),
    // otherwise the first valid source searching upward from rr_ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (r_state == S_LOCKED) begin
            w_gnt_any = commit_valid[r_lock_src];
            w_gnt_idx = r_lock_src;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                if (!w_gnt_any && commit_valid[IDX_W'((int'(r_rr_ptr) + k) % NUM_REQS)]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQS);
                end
            end
        end
        if (reset) begin
            w_gnt_any = 1'b0;
        end
    end

    assign w_ready      = w_gnt_any ? (NUM_REQS'(1) << w_gnt_idx) : '0;
    assign commit_ready = w_ready;
    assign w_beat       = commit_t'(commit_data[w_gnt_idx]);
    // A granted source is valid by construction, so a grant is a fire.
    assign w_emit       = w_gnt_any & w_beat.wb & (|w_beat.tmask);
    assign w_stall      = |(commit_valid & ~w_ready);

    // Lock FSM next state and round-robin pointer update on each fire.
    always_comb begin
        w_state_next    = r_state;
        w_lock_src_next = r_lock_src;
        w_rr_ptr_next   = r_rr_ptr;
        if (w_gnt_any) begin
            if (w_beat.eop) begin
                w_state_next  = S_IDLE;
                w_rr_ptr_next = (w_gnt_idx == IDX_W'(NUM_REQS - 1)) ? '0
                                                                      : w_gnt_idx + IDX_W'(1);
            end else begin
                w_state_next    = S_LOCKED;
                w_lock_src_next = w_gnt_idx;
            end
        end
    end

    // Lock state, lock owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its peers.
        if (reset) begin
            r_state    <= S_IDLE;
            r_lock_src <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_src <= w_lock_src_next;
            r_rr_ptr   <= w_rr_ptr_next;
        end
    end

    // Writeback valid: one cycle after an eligible fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= w_emit;
        end
    end

    // Writeback payload: loaded on an eligible fire, held otherwise.
    always_ff @(posedge clk) begin
        // NOTE: the payload is qualified by r_wb_valid, so it carries no
        // reset; only control state needs a known value after reset.
        if (w_emit) begin
            r_wb_data <= {w_beat.uuid, w_beat.wis, w_beat.tmask, w_beat.rd,
                          w_beat.data, w_beat.eop};
        end
    end

    // Stall counter: cycles where some valid source was not granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf <= '0;
        end else if (w_stall && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign writeback_valid = r_wb_valid;
    assign writeback_data  = r_wb_data;
    assign perf_stalls     = r_perf;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Bench for vx_writeback_arb: directed scenarios with literal expectations,
// then random traffic against a behavioural model and per-source scoreboard.
module tb_vx_writeback_arb;

    localparam int N    = 4;
    localparam int NT   = 4;
    localparam int XL   = 32;
    localparam int NRB  = 6;
    localparam int WIS  = 2;
    localparam int UW   = 44;
    localparam int DW   = NT * XL;
    localparam int DIN  = UW + WIS + NT + NRB + 1 + DW + 2;
    localparam int DOUT = UW + WIS + NT + NRB + DW + 1;

    typedef struct packed {
        logic [UW-1:0]  uuid;
        logic [WIS-1:0] wis;
        logic [NT-1:0]  tmask;
        logic [NRB-1:0] rd;
        logic           wb;
        logic [DW-1:0]  data;
        logic           sop;
        logic           eop;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           cv;
    logic [N-1:0]           cr;
    logic [N-1:0][DIN-1:0]  cd;
    logic                   wv;
    logic [DOUT-1:0]        wd;
    logic [31:0]            ps;

    vx_writeback_arb dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (cv),
        .commit_ready    (cr),
        .commit_data     (cd),
        .writeback_valid (wv),
        .writeback_data  (wd),
        .perf_stalls     (ps)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int              m_lock   = -1;
    int              m_rr     = 0;
    int              m_g      = -1;
    logic [N-1:0]    m_em     = '0;
    logic            m_wv     = 1'b0;
    logic [DOUT-1:0] m_wd     = '0;
    longint          m_stalls = 0;

    // Scoreboard / generator state
    logic [DOUT-1:0] sbq[N][$];
    int              rem[N];
    int              plen[N];
    bit              cur_elig[N];
    logic [N-1:0]    fired;
    int              seq = 0;
    bit              sb_en = 0;
    bit              prev_open = 0;
    int              prev_src = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DOUT-1:0] out_of(input beat_t b);
        return {b.uuid, b.wis, b.tmask, b.rd, b.data, b.eop};
    endfunction

    function automatic beat_t mk(input int src, input int rd, input bit wb,
                                 input logic [NT-1:0] tm, input bit sop, input bit eop);
        beat_t b;
        b.uuid  = UW'(src);
        b.wis   = '0;
        b.tmask = tm;
        b.rd    = NRB'(rd);
        b.wb    = wb;
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.sop   = sop;
        b.eop   = eop;
        return b;
    endfunction

    // Who must be served this cycle: lock owner if any, else first valid from rr.
    function automatic int model_grant();
        if (reset) return -1;
        if (m_lock >= 0) return cv[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (cv[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Compare everything observable against the model, mid-cycle.
    task automatic sample();
        int src;
        logic [DOUT-1:0] exp;
        @(negedge clk);
        m_g  = model_grant();
        m_em = (m_g >= 0) ? (N'(1) << m_g) : '0;
        check("ready", cr, m_em);
        check("wb_valid", wv, m_wv);
        if (m_wv) check("wb_data", wd, m_wd);
        check("perf_stalls", ps, m_stalls[31:0]);
        fired = cv & cr;
        if (sb_en && wv) begin
            src = int'(wd[DOUT-UW +: 2]);
            check("sb_avail", sbq[src].size() > 0, 1);
            if (sbq[src].size() > 0) begin
                exp = sbq[src].pop_front();
                check("sb_order", wd, exp);
            end
            if (prev_open) check("no_interleave", src, prev_src);
            prev_open = !wd[0];
            prev_src  = src;
        end
    endtask

    // Apply the clock edge to the model.
    task automatic advance();
        beat_t b;
        @(posedge clk);
        if (reset) begin
            m_lock   = -1;
            m_rr     = 0;
            m_wv     = 1'b0;
            m_stalls = 0;
        end else begin
            if (((cv & ~m_em) != '0) && (m_stalls < 64'hFFFF_FFFF)) m_stalls++;
            m_wv = 1'b0;
            if (m_g >= 0) begin
                b = cd[m_g];
                if (b.eop) begin
                    m_lock = -1;
                    m_rr   = (m_g + 1) % N;
                end else begin
                    m_lock = m_g;
                end
                if (b.wb && (b.tmask != '0)) begin
                    m_wv = 1'b1;
                    m_wd = out_of(b);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cv    = '0;
        sample();
        advance();
        sample();
        check("rst_wbv", wv, 0);
        check("rst_perf", ps, 0);
        advance();
        reset = 1'b0;
    endtask

    // Produce the next beat of source i's random packet stream.
    task automatic gen(input int i);
        beat_t b;
        if (rem[i] == 0) begin
            plen[i] = $urandom_range(1, 3);
            rem[i]  = plen[i];
            b.sop   = 1'b1;
        end else begin
            b.sop = 1'b0;
        end
        b.eop = (rem[i] == 1);
        rem[i]--;
        b.wb    = ($urandom_range(0, 3) != 0);
        b.tmask = NT'($urandom);
        if (b.eop && plen[i] > 1) begin
            b.wb       = 1'b1;
            b.tmask[0] = 1'b1;
        end
        b.rd   = NRB'($urandom);
        b.wis  = WIS'($urandom);
        b.uuid = (UW'(seq) << 4) | UW'(i);
        seq++;
        b.data = {$urandom, $urandom, $urandom, $urandom};
        cd[i]  = b;
        cur_elig[i] = b.wb && (b.tmask != '0);
        if (cur_elig[i]) sbq[i].push_back(out_of(b));
    endtask

    logic [N-1:0] exp026[5];

    initial begin
        reset = 1'b1;
        cv    = '0;
        cd    = '0;
        exp026 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // All sources valid with single-beat packets: strict rotation.
        do_reset();
        for (int i = 0; i < N; i++) cd[i] = mk(i, i, 1, 4'hF, 1, 1);
        cv = '1;
        for (int c = 0; c < 5; c++) begin
            sample();
            check("r026_grant", cr, exp026[c]);
            if (c >= 1) begin
                check("r026_wbv", wv, 1);
                check("r026_rd", wd[1+DW +: NRB], c - 1);
            end
            advance();
        end

        // 3-beat packet from source 1 blocks source 2 for three fires.
        do_reset();
        cd[2] = mk(2, 2, 1, 4'hF, 1, 1);
        cd[1] = mk(1, 10, 1, 4'hF, 1, 0);
        cv    = 4'b0110;
        sample(); check("r027_lock", cr, 4'b0010); advance();
        cd[1] = mk(1, 11, 1, 4'hF, 0, 0);
        sample(); check("r027_lock", cr, 4'b0010); advance();
        cd[1] = mk(1, 12, 1, 4'hF, 0, 1);
        sample(); check("r027_lock", cr, 4'b0010); advance();
        cv[1] = 1'b0;
        sample(); check("r027_src2", cr, 4'b0100); check("r027_stalls", ps, 3); advance();
        cv = '0;

        // Locked source 1 bubbles for two cycles while source 0 waits.
        do_reset();
        cd[1] = mk(1, 20, 1, 4'hF, 1, 0);
        cv    = 4'b0010;
        sample(); check("r028_lock", cr, 4'b0010); advance();
        cd[0] = mk(0, 21, 1, 4'hF, 1, 1);
        cv    = 4'b0001;
        sample(); check("r028_bubble", cr, 0); advance();
        sample(); check("r028_bubble", cr, 0); check("r028_nowb", wv, 0); advance();
        cd[1] = mk(1, 22, 1, 4'hF, 0, 1);
        cv    = 4'b0011;
        sample(); check("r028_resume", cr, 4'b0010); check("r028_nowb", wv, 0); advance();
        cv = 4'b0001;
        sample();
        check("r028_src0", cr, 4'b0001);
        check("r028_wb", wv, 1);
        check("r028_rd", wd[1+DW +: NRB], 22);
        check("r028_stalls", ps, 3);
        advance();
        cv = '0;

        // wb=0 and tmask=0 beats are consumed silently and advance rr.
        do_reset();
        cd[0] = mk(0, 30, 0, 4'hF, 1, 1);
        cv    = 4'b0001;
        sample(); check("r029_wb0_acc", cr, 4'b0001); advance();
        cd[1] = mk(1, 31, 1, 4'h0, 1, 1);
        cd[0] = mk(0, 32, 1, 4'hF, 1, 1);
        cv    = 4'b0011;
        sample(); check("r029_tm0_acc", cr, 4'b0010); check("r029_nowb", wv, 0); advance();
        sample(); check("r029_rr", cr, 4'b0001); check("r029_nowb", wv, 0); advance();
        cv = '0;
        sample(); check("r029_wb", wv, 1); check("r029_rd", wd[1+DW +: NRB], 32); advance();

        // Reset in the middle of a packet from source 3 drops the lock.
        do_reset();
        cd[3] = mk(3, 40, 0, 4'hF, 1, 0);
        cv    = 4'b1000;
        sample(); check("r030_lock", cr, 4'b1000); advance();
        reset = 1'b1;
        cd[3] = mk(3, 41, 1, 4'hF, 0, 1);
        cd[0] = mk(0, 42, 1, 4'hF, 1, 1);
        cv    = 4'b1001;
        sample(); check("r030_rdy_rst", cr, 0); advance();
        sample();
        check("r030_rdy_rst", cr, 0);
        check("r030_wbv_rst", wv, 0);
        check("r030_perf_rst", ps, 0);
        advance();
        reset = 1'b0;
        sample();
        check("r030_src0", cr, 4'b0001);
        check("r030_nowb", wv, 0);
        check("r030_perf", ps, 0);
        advance();
        cv = '0;

        // Random traffic with model and per-source scoreboard.
        do_reset();
        sb_en     = 1;
        prev_open = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            gen(i);
            cv[i] = ($urandom_range(0, 9) < 7);
        end
        repeat (10000) begin
            sample();
            advance();
            for (int i = 0; i < N; i++) begin
                if (fired[i]) gen(i);
                cv[i] = ($urandom_range(0, 9) < 7);
            end
        end
        cv = '0;
        repeat (2) begin
            sample();
            advance();
        end
        for (int i = 0; i < N; i++) begin
            check("sb_leftover", sbq[i].size(), cur_elig[i] ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
